// File: rtl/conv1d_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv1d_pkg : shared FSM state type and saturation / ReLU helpers.  Rev 1.0
// ---------------------------------------------------------------------------
package conv1d_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUT     = 2'd2
   } state_t;

   // Clamp a wide signed value into the signed range of a width-bit word.
   function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                    input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)      return hi;
      else if (value < lo) return lo;
      else                 return value;
   endfunction

   function automatic logic signed [63:0] relu(input logic signed [63:0] value);
      return (value < 64'sd0) ? 64'sd0 : value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_mac_lane : one saturating multiply-accumulate lane.  Rev 1.0
// ---------------------------------------------------------------------------
module conv_mac_lane
   import conv1d_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] f,
   output logic signed [WIDTH-1:0] acc
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [WIDTH-1:0]   prod_sat;
   logic signed [WIDTH:0]     sum;
   logic signed [WIDTH-1:0]   acc_q;

   // acc is the saturated running sum including this cycle's tap, so the
   // final tap can be captured by the parent on the same edge it lands.
   assign prod     = (2*WIDTH)'(x) * (2*WIDTH)'(f);
   assign prod_sat = WIDTH'(sat_trunc(64'(prod), WIDTH));
   assign sum      = (WIDTH+1)'(acc_q) + (WIDTH+1)'(prod_sat);
   assign acc      = WIDTH'(sat_trunc(64'(sum), WIDTH));

   always_ff @(posedge clk) begin
      if (clr)     acc_q <= '0;
      else if (en) acc_q <= acc;
   end

endmodule
`default_nettype wire

// File: rtl/conv1d_par_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv1d_par_stream : streaming 1-D convolution with P parallel MAC lanes.
// Rev 1.0
// ---------------------------------------------------------------------------
module conv1d_par_stream
   import conv1d_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int LENX  = 16,
   parameter  int LENF  = 4,
   parameter  int P     = 2,
   parameter  int RELU  = 1,
   localparam int SIZE  = LENX - LENF + 1,
   localparam int ADDRX = $clog2(LENX),
   localparam int ADDRF = $clog2(LENF)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] s_data_in_x,
   input  logic                    s_valid_x,
   output logic                    s_ready_x,
   output logic [ADDRF-1:0]        f_addr,
   input  logic signed [WIDTH-1:0] f_data,
   output logic signed [WIDTH-1:0] m_data_out_y,
   output logic                    m_valid_y,
   input  logic                    m_ready_y
);

   localparam int BW = $clog2(LENX + P + LENF) + 1;
   localparam int TW = $clog2(LENF + 1);
   localparam logic [BW-1:0]    P_B      = BW'(P);
   localparam logic [BW-1:0]    SIZE_B   = BW'(SIZE);
   localparam logic [BW-1:0]    ONE_B    = BW'(1);
   localparam logic [TW-1:0]    LAST_TAP = TW'(LENF);
   localparam logic [ADDRX-1:0] LAST_X   = ADDRX'(LENX - 1);

   state_t state, state_next;

   logic signed [WIDTH-1:0] x_mem     [LENX];
   logic signed [WIDTH-1:0] out_reg   [P];
   logic signed [WIDTH-1:0] lane_sum  [P];
   logic signed [WIDTH-1:0] latch_val [P];
   logic signed [WIDTH-1:0] out_sel;
   logic [ADDRX-1:0]        wr_idx;
   logic [TW-1:0]           tap;
   logic [BW-1:0]           base, out_idx, remain, last_idx;
   logic [P-1:0]            active;
   logic                    x_fire, y_fire, last_y, wrap;
   logic                    lane_clr, lane_en;

   always_ff @(posedge clk) begin
      if (reset) state <= LOAD;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      s_ready_x    = 1'b0;
      m_valid_y    = 1'b0;
      m_data_out_y = '0;
      case (state)
         LOAD: begin
            s_ready_x = !reset;
            if (s_valid_x && !reset && wr_idx == LAST_X) state_next = COMPUTE;
         end
         COMPUTE: begin
            if (tap == LAST_TAP) state_next = OUT;
         end
         OUT: begin
            m_valid_y    = !reset;
            m_data_out_y = reset ? '0 : out_sel;
            if (m_ready_y && last_y) state_next = wrap ? LOAD : COMPUTE;
         end
         default: state_next = LOAD;
      endcase
   end

   assign x_fire   = s_valid_x && s_ready_x;
   assign y_fire   = m_valid_y && m_ready_y;
   assign remain   = SIZE_B - base;
   assign last_idx = (remain < P_B) ? remain - ONE_B : P_B - ONE_B;
   assign last_y   = (out_idx == last_idx);
   assign wrap     = (base + P_B) >= SIZE_B;
   assign f_addr   = (reset || tap >= LAST_TAP) ? '0 : ADDRF'(tap);

   // Tap c is addressed in cycle c and its ROM word accumulates in cycle c+1.
   assign lane_en  = (state == COMPUTE) && (tap != '0);
   assign lane_clr = reset || ((state == COMPUTE) && (tap == LAST_TAP));

   for (genvar j = 0; j < P; j++) begin : g_lane
      logic [BW-1:0]           rd_idx;
      logic signed [WIDTH-1:0] x_sel;

      assign active[j] = (base + BW'(j)) < SIZE_B;

      always_comb begin
         rd_idx = base + BW'(j) + BW'(tap) - ONE_B;
         x_sel  = '0;
         for (int k = 0; k < LENX; k++) begin
            if (rd_idx == BW'(k)) x_sel = x_mem[k];
         end
      end

      conv_mac_lane #(.WIDTH(WIDTH)) u_lane (
         .clk (clk),
         .clr (lane_clr),
         .en  (lane_en && active[j]),
         .x   (x_sel),
         .f   (f_data),
         .acc (lane_sum[j])
      );

      assign latch_val[j] = !active[j] ? '0 :
                            (RELU != 0) ? WIDTH'(relu(64'(lane_sum[j]))) : lane_sum[j];
   end

   always_comb begin
      out_sel = '0;
      for (int k = 0; k < P; k++) begin
         if (out_idx == BW'(k)) out_sel = out_reg[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx  <= '0;
         tap     <= '0;
         base    <= '0;
         out_idx <= '0;
         for (int j = 0; j < P; j++) out_reg[j] <= '0;
      end else begin
         if (x_fire) begin
            x_mem[wr_idx] <= s_data_in_x;
            wr_idx        <= (wr_idx == LAST_X) ? '0 : wr_idx + ADDRX'(1);
         end
         if (state == COMPUTE) begin
            if (tap == LAST_TAP) begin
               tap <= '0;
               for (int j = 0; j < P; j++) out_reg[j] <= latch_val[j];
            end else begin
               tap <= tap + TW'(1);
            end
         end
         if (y_fire) begin
            if (last_y) begin
               out_idx <= '0;
               base    <= wrap ? '0 : base + P_B;
            end else begin
               out_idx <= out_idx + ONE_B;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_par_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_conv1d_par_stream : directed self-checking bench over five configurations.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_conv1d_par_stream;

   localparam int NI = 5;
   localparam int CL [NI] = '{8, 8, 16, 16, 16};
   localparam int CP [NI] = '{2, 2, 1, 4, 13};
   localparam int CR [NI] = '{1, 0, 0, 0, 0};

   logic clk;
   logic reset;
   logic signed [15:0] xin [NI];
   logic               vx  [NI];
   logic               rx  [NI];
   logic [1:0]         fa  [NI];
   logic signed [15:0] fd  [NI];
   logic signed [15:0] yd  [NI];
   logic               vy  [NI];
   logic               ry  [NI];

   int rom [4];
   int xv  [16];
   int exp_q [$];
   int cur, n_out, checks, errs, ph;
   bit bp_mode;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      conv1d_par_stream #(
         .WIDTH(16), .LENX(CL[gi]), .LENF(4), .P(CP[gi]), .RELU(CR[gi])
      ) u_dut (
         .clk          (clk),
         .reset        (reset),
         .s_data_in_x  (xin[gi]),
         .s_valid_x    (vx[gi]),
         .s_ready_x    (rx[gi]),
         .f_addr       (fa[gi]),
         .f_data       (fd[gi]),
         .m_data_out_y (yd[gi]),
         .m_valid_y    (vy[gi]),
         .m_ready_y    (ry[gi])
      );
      always @(posedge clk) fd[gi] <= 16'(rom[fa[gi]]);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input bit ok, input string nm, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic longint clampw(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Direct-form convolution with per-step saturation and optional ReLU.
   function automatic void model(input int ci);
      longint acc;
      for (int k = 0; k < CL[ci] - 3; k++) begin
         acc = 0;
         for (int c = 0; c < 4; c++)
            acc = clampw(acc + clampw(longint'(rom[c]) * longint'(xv[k + c])));
         if (CR[ci] != 0 && acc < 0) acc = 0;
         exp_q.push_back(int'(acc));
      end
   endfunction

   task automatic cmp_loop();
      bit                 hold;
      logic signed [15:0] hold_d;
      int                 e;
      hold = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            hold = 1'b0;
         end else begin
            if (hold) chk(vy[cur] == 1'b1 && yd[cur] == hold_d, "hold_stable",
                          longint'(yd[cur]), longint'(hold_d));
            if (vy[cur] && ry[cur]) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "extra_output", longint'(yd[cur]), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk(int'(yd[cur]) == e, "y_data", longint'(yd[cur]), longint'(e));
               end
               n_out++;
            end
            hold   = vy[cur] && !ry[cur];
            hold_d = yd[cur];
         end
      end
   endtask

   task automatic rdy_loop();
      logic r;
      forever begin
         @(posedge clk);
         #1;
         ph++;
         r = bp_mode ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
         for (int i = 0; i < NI; i++) ry[i] = r;
      end
   endtask

   // Leaves the caller 1 time unit after the edge that accepted the last x.
   task automatic send_x(input int ci, input bit gaps);
      int t;
      @(posedge clk);
      #1;
      cur = ci;
      for (int i = 0; i < CL[ci]; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            vx[ci] = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         vx[ci]  = 1'b1;
         xin[ci] = 16'(xv[i]);
         t = 0;
         @(negedge clk);
         while (!rx[ci] && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) chk(1'b0, "x_accept_timeout", t, 0);
         @(posedge clk);
         #1;
      end
      vx[ci] = 1'b0;
   endtask

   task automatic finish_vec(input int ci, input int lat_exp, input int n0);
      int lat, t;
      if (lat_exp > 0) begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!vy[ci] && lat < 40);
         chk(lat == lat_exp, "first_valid_latency", lat, lat_exp);
      end
      t = 0;
      while (n_out - n0 < CL[ci] - 3 && t < 4000) begin
         @(posedge clk);
         t++;
      end
      chk(n_out - n0 == CL[ci] - 3, "output_count", n_out - n0, CL[ci] - 3);
      @(negedge clk);
      chk(rx[ci] == 1'b1, "s_ready_back", longint'(rx[ci]), 1);
      chk(exp_q.size() == 0, "all_expected_consumed", exp_q.size(), 0);
   endtask

   task automatic set_rom(input int a, input int b, input int c, input int d);
      rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
   endtask

   task automatic run(input int ci, input int lat_exp, input bit gaps);
      int n0;
      n0 = n_out;
      send_x(ci, gaps);
      finish_vec(ci, lat_exp, n0);
   endtask

   initial begin
      int lit_a [5];
      int lit_b [5];
      int n0, t, seen;
      lit_a = '{20, 30, 40, 50, 60};
      lit_b = '{-1, -2, -3, -4, -5};
      reset = 1'b1; cur = 0; bp_mode = 1'b0;
      checks = 0; errs = 0; n_out = 0; ph = 0;
      for (int i = 0; i < NI; i++) begin
         vx[i] = 1'b0; xin[i] = '0; ry[i] = 1'b1;
      end
      set_rom(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) xv[i] = 0;
      fork
         cmp_loop();
         rdy_loop();
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk(rx[i] == 1'b0, "reset_s_ready", longint'(rx[i]), 0);
         chk(vy[i] == 1'b0, "reset_m_valid", longint'(vy[i]), 0);
         chk(yd[i] == '0,  "reset_m_data", longint'(yd[i]), 0);
         chk(fa[i] == '0,  "reset_f_addr", longint'(fa[i]), 0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk(rx[i] == 1'b1, "ready_after_reset", longint'(rx[i]), 1);

      // Basic: f={1,2,3,4}, x=0..7
      set_rom(1, 2, 3, 4);
      for (int i = 0; i < 8; i++) xv[i] = i;
      model(0);
      for (int k = 0; k < 5; k++) chk(exp_q[k] == lit_a[k], "model_pin_basic", exp_q[k], lit_a[k]);
      run(0, 6, 1'b0);

      // Backpressure 1,0,0,1 plus random input gaps
      model(0);
      bp_mode = 1'b1;
      run(0, 0, 1'b1);
      bp_mode = 1'b0;

      // Saturation
      set_rom(4, 4, 4, 4);
      for (int i = 0; i < 8; i++) xv[i] = 32767;
      model(0);
      chk(exp_q[0] == 32767, "model_pin_sat_pos", exp_q[0], 32767);
      run(0, 0, 1'b0);
      for (int i = 0; i < 8; i++) xv[i] = -32768;
      model(1);
      chk(exp_q[4] == -32768, "model_pin_sat_neg", exp_q[4], -32768);
      run(1, 0, 1'b0);

      // ReLU on and off
      set_rom(-1, 0, 0, 0);
      for (int i = 0; i < 8; i++) xv[i] = i + 1;
      model(0);
      chk(exp_q[2] == 0, "model_pin_relu", exp_q[2], 0);
      run(0, 0, 1'b0);
      model(1);
      for (int k = 0; k < 5; k++) chk(exp_q[k] == lit_b[k], "model_pin_norelu", exp_q[k], lit_b[k]);
      run(1, 0, 1'b0);

      // Parallel scaling P=1, 4, 13 with random data
      for (int ci = 2; ci < NI; ci++) begin
         for (int c = 0; c < 4; c++) rom[c] = int'($urandom_range(0, 200)) - 100;
         for (int i = 0; i < 16; i++) xv[i] = int'($urandom_range(0, 600)) - 300;
         model(ci);
         run(ci, (ci == 4) ? 6 : 0, 1'b0);
      end

      // Reset during COMPUTE
      set_rom(1, 2, 3, 4);
      for (int i = 0; i < 8; i++) xv[i] = i;
      model(0);
      send_x(0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk(rx[0] == 1'b0, "rst_compute_ready_low", longint'(rx[0]), 0);
      chk(vy[0] == 1'b0, "rst_compute_valid_low", longint'(vy[0]), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk(vy[0] == 1'b0, "rst_compute_valid_after", longint'(vy[0]), 0);
      chk(rx[0] == 1'b1, "rst_compute_ready_after", longint'(rx[0]), 1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (vy[0]) seen++;
      end
      chk(seen == 0, "no_stale_output", seen, 0);

      // Reset during OUT after two results
      model(0);
      n0 = n_out;
      send_x(0, 1'b0);
      t = 0;
      while (n_out - n0 < 2 && t < 200) begin
         @(posedge clk);
         t++;
      end
      chk(n_out - n0 == 2, "two_before_reset", n_out - n0, 2);
      #1 reset = 1'b1;
      @(negedge clk);
      chk(vy[0] == 1'b0, "rst_out_valid_low", longint'(vy[0]), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk(vy[0] == 1'b0, "rst_out_valid_after", longint'(vy[0]), 0);
      chk(rx[0] == 1'b1, "rst_out_ready_after", longint'(rx[0]), 1);

      // Fresh vector after the aborted one
      model(0);
      run(0, 6, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv1d_par_stream.md
Name: conv1d_par_stream

Overview:
- Streaming 1-D convolution engine, next generation of the single-MAC convolver.
- Accepts a LENX-sample signed input vector over a valid/ready slave port.
- Convolves it with a LENF-tap filter read from an external synchronous ROM, using P parallel MAC lanes.
- Streams the SIZE = LENX-LENF+1 results out over a valid/ready master port, with saturating arithmetic and optional ReLU.

Parameters:
- WIDTH, 16, signed data/filter/result width.
- LENX, 16, input vector length (>= LENF).
- LENF, 4, filter tap count (>= 2).
- P, 2, number of parallel MAC lanes (1 <= P <= SIZE; need not divide SIZE).
- RELU, 1, 1 = clamp negative results to 0; 0 = pass signed result.
- SIZE, LENX-LENF+1, derived output count.
- ADDRX, $clog2(LENX), derived.
- ADDRF, $clog2(LENF), derived.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- s_data_in_x  in  WIDTH  signed input sample.
- s_valid_x  in  1  input sample valid.
- s_ready_x  out  1  block can accept a sample.
- f_addr  out  ADDRF  filter ROM address.
- f_data  in  WIDTH  signed filter tap; ROM output registered, valid 1 cycle after f_addr.
- m_data_out_y  out  WIDTH  signed result.
- m_valid_y  out  1  result valid.
- m_ready_y  in  1  downstream accepts result.

Behaviour:
- Reset:
  - Single clock, synchronous active-high reset.
  - State LOAD, write index 0, base 0, accumulators 0.
  - s_ready_x=0 during reset cycle, then 1.
  - m_valid_y=0, m_data_out_y=0, f_addr=0.
  - Reset mid-operation aborts the vector; partial data is discarded, no stale output is emitted.
- Transfers: a transfer occurs on an edge where valid&&ready. Producers hold data stable while valid && !ready.
- FSM states LOAD, COMPUTE, OUT.
- LOAD:
  - s_ready_x=1; each transfer writes x[wr_idx], wr_idx++.
  - Gaps in s_valid_x are tolerated.
  - On the transfer with wr_idx==LENX-1: wr_idx<=0, go to COMPUTE.
  - s_ready_x is 0 in COMPUTE and OUT.
- COMPUTE (one lane group, base..base+P-1):
  - Cycle c=0..LENF-1 drives f_addr=c.
  - Cycle c+1 each active lane j computes acc_j += sat(f_data * x[base+j+c]).
  - X storage is a register array so all P lanes read in parallel.
  - Lane j is active iff base+j < SIZE; inactive lanes hold 0 and produce no output.
  - After the LENF-th accumulate, results are latched into out_reg[0..P-1], accumulators are cleared, and the FSM goes to OUT.
  - The group occupies LENF+1 cycles in COMPUTE.
  - m_valid_y rises LENF+2 cycles after the edge accepting the last x (first group) or the last y of the previous group.
- Arithmetic:
  - Product is 2*WIDTH bits, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Sum is WIDTH+1 bits, clamped to the same range every tap, so saturation is sticky per step.
  - ReLU is applied at the latch into out_reg.
- OUT:
  - Emits out_reg[0], out_reg[1], ... in lane order, one per transfer; data and valid are held while m_ready_y=0.
  - After the last active lane transfers: base += P.
  - If base >= SIZE: base<=0, go to LOAD (s_ready_x=1 the next cycle).
  - Otherwise go to COMPUTE.
- No overlap of load and output in this generation.
- Total outputs per vector: exactly SIZE, in index order y[0..SIZE-1].
- m_ready_y held high permanently gives no bubbles inside a group.

Decomposition:
- Package conv1d_pkg:
  - state_t enum {LOAD, COMPUTE, OUT}.
  - Function sat_trunc(value, width) for the clamp.
  - Function relu().
- Sub-module conv_mac_lane, instantiated P times via generate.
  - Inputs: clr, en, x, f.
  - Output: saturated accumulator.
  - Holds the product/sum saturation.
- Top holds the FSM, X register array, counters (wr_idx, tap c, base, out_idx), and out_reg.

Test Plan:
- Basic, partial group, zero backpressure: WIDTH=16, LENX=8, LENF=4, P=2, RELU=1; ROM f={1,2,3,4}; x=0..7 streamed → y=20,30,40,50,60, in order. Exactly 5 outputs; the partial last group emits only lane 0. s_ready_x returns to 1 after y=60 transfers.
- Backpressure: same stimulus; m_ready_y toggles 1,0,0,1 repeating and s_valid_x has random gaps → identical y sequence. m_data_out_y is stable while m_valid_y=1 && m_ready_y=0; no duplicate or dropped results.
- Saturation: x all 32767, f all 4 → every y=32767. x all -32768, f all 4, RELU=0 → every y=-32768.
- ReLU: f={-1,0,0,0}, x=1..8. RELU=1 → y all 0. RELU=0 → y=-1,-2,-3,-4,-5.
- Parallel scaling: LENX=16, LENF=4, P=1, 4 and 13 with random x/f → match the golden model bit-exactly. P=13 yields one group; m_valid_y rises LENF+2=6 cycles after the last x transfer.
- Reset mid-operation: assert reset for 1 cycle during COMPUTE, then again during OUT after 2 of 5 outputs → m_valid_y=0 the next cycle, s_ready_x=1 the cycle after reset deasserts. A fresh vector x=0..7 gives 20,30,40,50,60 with no stale outputs.
